// File: rtl/fetch_if_id.sv
// Fetch stage with IF/ID pipeline register: PC, RUN/HALT FSM, stall/flush
// handling. The instruction memory is read combinationally at imem_addr.
module fetch_if_id (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic [3:0]  opcode,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] pc_plus2_q;
    logic        valid_q;

    logic [15:0] pc_plus2_d;
    logic        is_hlt;

    // The 16-bit add wraps naturally, so 0xFFFE advances to 0x0000.
    assign pc_plus2_d = pc_q + 16'd2;
    assign is_hlt     = (imem_data[15:12] == 4'b1111);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= 16'h0000;
            instr_q    <= 16'h0000;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (flush) begin
            // A taken branch older than HLT may legally pull us out of HALT.
            state_q    <= RUN;
            pc_q       <= {branch_target[15:1], 1'b0};
            instr_q    <= 16'h0000;
            valid_q    <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    instr_q    <= imem_data;
                    pc_plus2_q <= pc_plus2_d;
                    valid_q    <= 1'b1;
                    if (is_hlt) begin
                        state_q <= HALT;
                    end else begin
                        pc_q    <= pc_plus2_d;
                    end
                end
                HALT: begin
                    instr_q <= 16'h0000;
                    valid_q <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pc_plus2_q;
    assign ifid_valid    = valid_q;
    assign opcode        = instr_q[15:12];
    assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id: small combinational imem model, linear steps,
// hand-computed expectations checked with immediate assertions.
module tb_fetch_if_id;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [15:0] branch_target;
    logic [15:0] imem_addr, imem_data;
    logic [15:0] ifid_instr, ifid_pc_plus2;
    logic        ifid_valid, halted;
    logic [3:0]  opcode;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[8:1]];

    fetch_if_id dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus2(ifid_pc_plus2),
        .ifid_valid   (ifid_valid),
        .opcode       (opcode),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [15:0] addr, input logic [15:0] instr,
                           input logic [15:0] pp2, input logic vld, input logic hlt);
        chk({tag, ".addr"},   imem_addr, addr);
        chk({tag, ".instr"},  ifid_instr, instr);
        chk({tag, ".pp2"},    ifid_pc_plus2, pp2);
        chk({tag, ".valid"},  {15'd0, ifid_valid}, {15'd0, vld});
        chk({tag, ".halted"}, {15'd0, halted}, {15'd0, hlt});
        chk({tag, ".opcode"}, {12'd0, opcode}, {12'd0, instr[15:12]});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h1234;  // 0x0000
        mem[1]   = 16'h5678;  // 0x0002
        mem[2]   = 16'h2001;  // 0x0004
        mem[3]   = 16'h3003;  // 0x0006
        mem[4]   = 16'h4004;  // 0x0008
        mem[5]   = 16'hF000;  // 0x000A HLT
        mem[16]  = 16'h7777;  // 0x0020
        mem[32]  = 16'h9999;  // 0x0040
        mem[255] = 16'h6ABC;  // 0xFFFE

        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 16'h0000;
        step();
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        rst = 1'b0;
        step();
        chk_all("fetch0", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);
        step();
        chk_all("fetch2", 16'h0004, 16'h5678, 16'h0004, 1'b1, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 16'h0004, 16'h5678, 16'h0004, 1'b1, 1'b0);
        end
        stall = 1'b0;
        step();
        chk_all("resume", 16'h0006, 16'h2001, 16'h0006, 1'b1, 1'b0);

        flush = 1'b1; stall = 1'b1; branch_target = 16'h0041;
        step();
        chk_all("flush_stall", 16'h0040, 16'h0000, 16'h0006, 1'b0, 1'b0);
        flush = 1'b0; stall = 1'b0;
        step();
        chk_all("after_flush", 16'h0042, 16'h9999, 16'h0042, 1'b1, 1'b0);

        flush = 1'b1; branch_target = 16'h0006;
        step();
        chk_all("redir6", 16'h0006, 16'h0000, 16'h0042, 1'b0, 1'b0);
        flush = 1'b0;
        step();
        chk_all("fetch6", 16'h0008, 16'h3003, 16'h0008, 1'b1, 1'b0);
        step();
        chk_all("fetch8", 16'h000A, 16'h4004, 16'h000A, 1'b1, 1'b0);
        step();
        chk_all("hlt", 16'h000A, 16'hF000, 16'h000C, 1'b1, 1'b1);
        step();
        chk_all("halt_bub1", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1);
        step();
        chk_all("halt_bub2", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1);
        stall = 1'b1;
        step();
        chk_all("halt_stall", 16'h000A, 16'h0000, 16'h000C, 1'b0, 1'b1);

        stall = 1'b0; flush = 1'b1; branch_target = 16'h0020;
        step();
        chk_all("unhalt", 16'h0020, 16'h0000, 16'h000C, 1'b0, 1'b0);
        flush = 1'b0;
        step();
        chk_all("fetch20", 16'h0022, 16'h7777, 16'h0022, 1'b1, 1'b0);

        flush = 1'b1; branch_target = 16'hFFFE;
        step();
        chk_all("redirFFFE", 16'hFFFE, 16'h0000, 16'h0022, 1'b0, 1'b0);
        flush = 1'b0;
        step();
        chk_all("wrap", 16'h0000, 16'h6ABC, 16'h0000, 1'b1, 1'b0);

        flush = 1'b1; branch_target = 16'h000A;
        step();
        chk_all("redirA", 16'h000A, 16'h0000, 16'h0000, 1'b0, 1'b0);
        flush = 1'b0;
        step();
        chk_all("hlt2", 16'h000A, 16'hF000, 16'h000C, 1'b1, 1'b1);

        rst = 1'b1; stall = 1'b1; flush = 1'b1; branch_target = 16'h0040;
        step();
        chk_all("rst_halt", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        step();
        chk_all("post_rst", 16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_if_id.md
FETCH_IF_ID -- requirements
Module: fetch_if_id

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-004 SHALL have port: flush  input  1  taken branch/PCS redirect; kill fetched instruction.
REQ-005 SHALL have port: branch_target  input  16  redirect PC, sampled only when flush=1.
REQ-006 SHALL have port: imem_addr  output  16  instruction memory address, byte-addressed.
REQ-007 SHALL have port: imem_data  input  16  instruction word; combinational read of imem_addr, same cycle.
REQ-008 SHALL have port: ifid_instr  output  16  registered instruction for decode.
REQ-009 SHALL have port: ifid_pc_plus2  output  16  registered fetch PC + 2, used for PCS and branch base.
REQ-010 SHALL have port: ifid_valid  output  1  1 = ifid_instr is a real instruction; 0 = bubble.
REQ-011 SHALL have port: opcode  output  4  ifid_instr[15:12], drives decode control unit directly.
REQ-012 SHALL have port: halted  output  1  1 while state = HALT.

Function
REQ-013 SHALL hold internal 16-bit pc and a 2-state FSM {RUN, HALT}; imem_addr = pc combinationally.
REQ-014 SHALL apply per-edge priority: rst > flush > stall > normal operation.
REQ-015 SHALL, in RUN, no stall/flush, imem_data[15:12] != 4'b1111: load ifid_instr=imem_data, ifid_pc_plus2=pc+2, ifid_valid=1; pc=pc+2.
REQ-016 SHALL, in RUN, no stall/flush, imem_data[15:12] == 4'b1111 (HLT): load IF/ID as REQ-015, pc unchanged, state -> HALT.
REQ-017 SHALL, in HALT, no stall/flush: pc unchanged; load bubble (ifid_instr=16'h0000, ifid_pc_plus2 unchanged, ifid_valid=0); remain HALT.
REQ-018 SHALL, on stall=1 (flush=0), in either state: pc, IF/ID contents, and state unchanged.
REQ-019 SHALL, on flush=1, in either state: pc=branch_target, ifid_instr=16'h0000, ifid_valid=0, ifid_pc_plus2 unchanged, state -> RUN (flush leaving HALT is legal: branch older than HLT was taken).
REQ-020 SHALL, when flush and stall both 1, perform flush only.
REQ-021 SHALL compute pc+2 modulo 2^16: pc 0xFFFE advances to 0x0000 and ifid_pc_plus2 = 0x0000.
REQ-022 SHALL force branch_target[0] to 0 when loading pc (PC always halfword aligned).
REQ-023 SHALL have one-cycle fetch latency: instruction at address A appears on ifid_instr on the edge after imem_addr = A, absent stall/flush.
REQ-024 SHALL drive opcode = ifid_instr[15:12] regardless of ifid_valid (bubble yields opcode 4'b0000; downstream gates with ifid_valid).
REQ-025 SHALL assert halted combinationally from state only; halted=1 the cycle after HLT is latched into IF/ID.

Reset
REQ-026 SHALL, on rst=1 at an edge: pc=0x0000, ifid_instr=0x0000, ifid_pc_plus2=0x0000, ifid_valid=0, state=RUN; outputs hold these values from the following cycle.
REQ-027 SHALL ignore stall, flush and imem_data in any cycle where rst=1, including mid-HALT and mid-stall.
REQ-028 SHALL begin fetching address 0x0000 in the first cycle after rst deasserts.

Verification
REQ-029 SHALL be verified: reset, then imem returns 0x1234 @0, 0x5678 @2 -> ifid_instr 0x1234/pc_plus2 0x0002, next cycle 0x5678/0x0004, ifid_valid=1, opcode 0x1 then 0x5.
REQ-030 SHALL be verified: stall=1 for 3 cycles at pc=0x0004 -> imem_addr stays 0x0004, IF/ID unchanged 3 cycles, fetch resumes at 0x0004 after release.
REQ-031 SHALL be verified: flush=1 and stall=1 together, branch_target=0x0041 -> pc=0x0040, ifid_valid=0, ifid_instr=0x0000 next cycle.
REQ-032 SHALL be verified: 0xF000 fetched at 0x000A -> ifid_instr=0xF000, halted=1, imem_addr held 0x000A, following cycles ifid_valid=0; then flush with target 0x0020 -> halted=0, fetch from 0x0020.
REQ-033 SHALL be verified: flush to 0xFFFE, non-HLT instruction -> ifid_pc_plus2=0x0000, next imem_addr=0x0000.
REQ-034 SHALL be verified: rst=1 asserted while halted and stall=1 -> next cycle halted=0, pc=0x0000, ifid_valid=0.
